token_inject_arbiter: RTL and testbench
=======================================

// Module: token_inject_arbiter
// PURPOSE
//  Clocked controller that schedules token injection into the asynchronous swirling ring (CUES) through its single merge stage.
//  Round-robin arbitrates two injection requesters (board buttons/switch logic) for the merge input, then runs the 4-phase SENDOUT/ACKIN handshake.
//  Tracks tokens in flight against a cap and paces injections with a tick divider so the swirl stays visible on LEDs.
// PARAMETERS
//  MAX_TOKENS  4      max tokens in flight in the ring; 1..(2**CNT_W-1)
//  CNT_W       3      width of the in-flight token counter
//  PACE_W      20     width of the pacing counter
//  PACE_CYC    100000 min clk cycles from one grant to the next grant
//  TO_CYC      1024   handshake timeout in clk cycles (used only with HS_TIMEOUT_EN)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous reset, active-high
//  req         in   2      injection requests, level; held until granted
//  gnt         out  2      one-hot, 1-cycle pulse when a requester's token is accepted by the ring
//  mer_sendout out  1      4-phase request to the merge stage
//  mer_ackin   in   1      4-phase ack from the merge stage; async, 2-FF synchronised internally
//  ret_pulse   in   1      1-cycle pulse, already synchronous: one token retired from the ring
//  tokens      out  CNT_W  tokens currently in flight
//  full        out  1      tokens == MAX_TOKENS
//  busy        out  1      FSM not in IDLE
//  err         out  1      sticky; cleared only by rst
// BEHAVIOUR
//  Reset values: gnt=0, mer_sendout=0, tokens=0, full=0, busy=0, err=0.
//  Reset also sets: state=IDLE, pace counter=0 (ready), round-robin pointer favours req[0], ack synchroniser=0.
//  rst mid-handshake: mer_sendout is 0 at the next edge. No token is counted and no gnt is issued.
//  ack_s is mer_ackin after 2 FFs, i.e. 2 cycles of latency.
//  FSM states: IDLE, REQ, REL, DRAIN.
//   IDLE->REQ  when |req && !full && pace_ok && !ack_s.
//    Winner: if only one req, that one. If both, the one not granted last (pointer), req[0] after reset.
//    Winner is latched. mer_sendout=1 from the cycle after IDLE.
//   REQ->REL  on ack_s==1. mer_sendout=0. Token count +1. gnt[winner] pulses for exactly 1 cycle (entry into REL).
//    Pointer moves to the other requester. Pace counter reloads to PACE_CYC-1.
//   REL->IDLE  on ack_s==0.
//   DRAIN: entered from IDLE if ack_s==1 with mer_sendout=0 (protocol violation).
//    Sets err. Returns to IDLE on ack_s==0.
//  pace_ok = (pace counter == 0). Counter decrements each cycle and saturates at 0.
//  Token counter:
//   Inject and ret_pulse in the same cycle: tokens unchanged.
//   ret_pulse with tokens==0: ignored, err set.
//   Never exceeds MAX_TOKENS; injection is blocked while full.
//  full and busy are registered from the next-state values, so they match tokens and state in the same cycle.
//  req deasserted while in REQ: handshake still completes. gnt pulses even if req has since dropped.
// CONFIGURATION
//  HS_TIMEOUT_EN defined:
//   A counter runs while in REQ. If ack_s has not risen after TO_CYC cycles: mer_sendout->0, err set.
//   No count change, no gnt. FSM goes to REL and waits for ack_s==0 (late ack handled there).
//  HS_TIMEOUT_EN undefined: REQ waits indefinitely. No timeout logic is synthesised.
// TESTING
//  Use PACE_CYC=8, TO_CYC=16, ack model responding 3 cycles after each edge.
//  T1 Reset: rst=1 for 3 clk with req=2'b11 -> all outputs 0, mer_sendout never rises.
//  T2 Single: req=2'b01 -> mer_sendout rises 1 clk after; gnt=2'b01 for 1 clk when ack_s rises; tokens=1.
//  T3 Fairness: req=2'b11 held -> grants alternate 01,10,01,10; grant spacing >= 8 clk.
//  T4 Cap: MAX_TOKENS=4, no ret_pulse -> exactly 4 grants, full=1, mer_sendout stays 0.
//     Then ret_pulse x1 -> tokens=3, full=0, a 5th grant follows.
//  T5 Simultaneous: ret_pulse in the same cycle as the REQ->REL transition -> tokens unchanged.
//     ret_pulse with tokens=0 -> err=1, tokens=0.
//  T6 With HS_TIMEOUT_EN: ack model disabled -> mer_sendout drops after 16 clk in REQ, err=1, gnt never pulses, tokens=0.
//     Without HS_TIMEOUT_EN: mer_sendout stays high.
//     rst mid-REQ -> mer_sendout=0 next clk.

Source files
------------

// File: rtl/token_inject_arbiter.sv
// -----------------------------------------------------------------------------
// token_inject_arbiter
//
// Schedules token injection into the asynchronous swirling ring through its
// single merge stage. Two level-held requesters are round-robin arbitrated.
// The winner's token is pushed with a 4-phase mer_sendout/mer_ackin handshake.
// Tokens in flight are counted against MAX_TOKENS. Grants are paced so that
// consecutive grants are at least PACE_CYC clocks apart, which keeps the swirl
// visible on the LEDs.
//
// Optional feature (compile-time macro HS_TIMEOUT_EN):
//   If defined, a REQ phase that sees no ack after TO_CYC cycles is abandoned.
//   mer_sendout drops and err is set. No token is counted and no gnt is issued.
//   If undefined, REQ waits indefinitely and no timeout logic is built.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   req[1:0]     injection requests, level, held until granted
//   gnt[1:0]     one-hot 1-cycle pulse when the ring accepts that requester's token
//   mer_sendout  4-phase request to the merge stage
//   mer_ackin    4-phase ack from the merge stage (asynchronous, synchronised here)
//   ret_pulse    1-cycle synchronous pulse: one token retired from the ring
//   tokens       tokens currently in flight
//   full         tokens == MAX_TOKENS
//   busy         handshake FSM not in IDLE
//   err          sticky protocol/accounting error, cleared only by rst
// -----------------------------------------------------------------------------
module token_inject_arbiter #(
    parameter int MAX_TOKENS = 4,
    parameter int CNT_W      = 3,
    parameter int PACE_W     = 20,
    parameter int PACE_CYC   = 100000,
    parameter int TO_CYC     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic             mer_sendout,
    input  logic             mer_ackin,
    input  logic             ret_pulse,
    output logic [CNT_W-1:0] tokens,
    output logic             full,
    output logic             busy,
    output logic             err
);

    // Reject parameter sets the counters cannot represent.
    if (MAX_TOKENS < 1 || MAX_TOKENS > (2**CNT_W - 1) || PACE_CYC < 1 ||
        PACE_CYC > 2**PACE_W || TO_CYC < 1) begin : g_bad_params
        $fatal(1, "token_inject_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, REQ, REL, DRAIN} state_t;

    state_t             state, state_nxt;
    logic               ack_meta, ack_s;
    logic               win;        // latched winner index for the running handshake
    logic               ptr;        // requester favoured when both request
    logic               pick;
    logic [PACE_W-1:0]  pace_cnt;
    logic               pace_ok;
    logic               start, accept, viol, to_fire;
    logic               timeout;
    logic [CNT_W-1:0]   tokens_nxt;
    logic               ret_err;

`ifdef HS_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC) + 1;
    logic [TO_W-1:0] to_cnt;

    // Counts cycles spent in REQ; value k means the (k+1)-th cycle in REQ.
    always_ff @(posedge clk) begin
        if (rst || state != REQ) to_cnt <= '0;
        else                     to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (state == REQ) && (to_cnt == TO_W'(TO_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign pace_ok = (pace_cnt == '0);
    // With a single requester it wins outright; the pointer only breaks ties.
    assign pick    = (req == 2'b11) ? ptr : req[1];

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        accept    = 1'b0;
        viol      = 1'b0;
        to_fire   = 1'b0;
        case (state)
            IDLE: begin
                // An ack while we are not requesting is a protocol violation
                // and takes priority over starting a new handshake.
                if (ack_s) begin
                    state_nxt = DRAIN;
                    viol      = 1'b1;
                end else if (|req && !full && pace_ok) begin
                    state_nxt = REQ;
                    start     = 1'b1;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_nxt = REL;
                    accept    = 1'b1;
                end else if (timeout) begin
                    // Abandon the request; a late ack is absorbed in REL.
                    state_nxt = REL;
                    to_fire   = 1'b1;
                end
            end
            REL:     if (!ack_s) state_nxt = IDLE;
            DRAIN:   if (!ack_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An injection and a retirement in the same cycle cancel out.
    always_comb begin
        tokens_nxt = tokens;
        ret_err    = 1'b0;
        if (accept && !ret_pulse) begin
            tokens_nxt = tokens + 1'b1;
        end else if (ret_pulse && !accept) begin
            if (tokens == '0) ret_err    = 1'b1;
            else              tokens_nxt = tokens - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ack_meta    <= 1'b0;
            ack_s       <= 1'b0;
            win         <= 1'b0;
            ptr         <= 1'b0;
            pace_cnt    <= '0;
            tokens      <= '0;
            full        <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            gnt         <= 2'b00;
            mer_sendout <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack_meta <= mer_ackin;
            ack_s    <= ack_meta;

            if (start)  win <= pick;
            if (accept) ptr <= ~win;

            if (accept)        pace_cnt <= PACE_W'(PACE_CYC - 1);
            else if (!pace_ok) pace_cnt <= pace_cnt - 1'b1;

            tokens <= tokens_nxt;
            // Registered from next-state values so they line up with tokens/state.
            full        <= (tokens_nxt == CNT_W'(MAX_TOKENS));
            busy        <= (state_nxt != IDLE);
            mer_sendout <= (state_nxt == REQ);
            gnt         <= accept ? (win ? 2'b10 : 2'b01) : 2'b00;

            if (viol || ret_err || to_fire) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_token_inject_arbiter.sv
// -----------------------------------------------------------------------------
// tb_token_inject_arbiter
//
// Directed self-checking bench for token_inject_arbiter with PACE_CYC=8 and
// TO_CYC=16. A merge-stage model echoes mer_sendout back on mer_ackin three
// sampling steps later; it can be disabled (ack_en) or forced high (force_ack).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// The fairness/cap sequence is a table of {req, retirements, expected gnt,
// expected tokens, expected full} records; the multi-cycle corners (reset,
// simultaneous inject/retire, underflow, drain, reset mid-REQ, timeout) are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_token_inject_arbiter;

    localparam int MAX_TOKENS = 4;
    localparam int CNT_W      = 3;
    localparam int PACE_W     = 20;
    localparam int PACE_CYC   = 8;
    localparam int TO_CYC     = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = 2'b11;
    logic [1:0]       gnt;
    logic             mer_sendout;
    logic             mer_ackin;
    logic             ret_pulse = 1'b0;
    logic [CNT_W-1:0] tokens;
    logic             full;
    logic             busy;
    logic             err;

    logic       ack_en    = 1'b1;
    logic       force_ack = 1'b0;
    logic [2:0] ack_d     = 3'b000;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    token_inject_arbiter #(
        .MAX_TOKENS (MAX_TOKENS),
        .CNT_W      (CNT_W),
        .PACE_W     (PACE_W),
        .PACE_CYC   (PACE_CYC),
        .TO_CYC     (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .mer_sendout (mer_sendout),
        .mer_ackin   (mer_ackin),
        .ret_pulse   (ret_pulse),
        .tokens      (tokens),
        .full        (full),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Merge-stage model: ack follows sendout with a 3-step delay.
    always @(negedge clk) ack_d = {ack_d[1:0], mer_sendout & ack_en};
    assign mer_ackin = ack_d[2] | force_ack;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d required < 20000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 2'b00;
        ret_pulse = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 0);
    endtask

    task automatic wait_sendout(input string name);
        int n = 0;
        @(negedge clk);
        while (!mer_sendout && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(mer_sendout), 1);
    endtask

    task automatic wait_gnt(output logic [1:0] g, output int gcyc);
        int n = 0;
        g    = 2'b00;
        gcyc = 0;
        while (n < 80 && g == 2'b00) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                g    = gnt;
                gcyc = cyc;
            end
            n++;
        end
        if (g == 2'b00) check("gnt_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0]       req;
        int               n_ret;
        logic [1:0]       exp_gnt;
        logic [CNT_W-1:0] exp_tok;
        logic             exp_full;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [1:0] g;
        int         gcyc;
        int         last_gcyc;
        int         hi;
        logic       seen_s;
        logic       seen_g;

        // req, retirements before, expected gnt, tokens, full
        vecs[0] = '{2'b11, 0, 2'b01, 3'd1, 1'b0};
        vecs[1] = '{2'b11, 0, 2'b10, 3'd2, 1'b0};
        vecs[2] = '{2'b11, 0, 2'b01, 3'd3, 1'b0};
        vecs[3] = '{2'b11, 0, 2'b10, 3'd4, 1'b1};
        vecs[4] = '{2'b11, 1, 2'b01, 3'd4, 1'b1};
        vecs[5] = '{2'b01, 1, 2'b01, 3'd4, 1'b1};
        vecs[6] = '{2'b11, 1, 2'b10, 3'd4, 1'b1};
        vecs[7] = '{2'b10, 2, 2'b10, 3'd3, 1'b0};

        // T1: reset held 3 clocks with both requests asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_sendout_in_reset", 32'(mer_sendout), 0);
        end
        check("t1_gnt",    32'(gnt),    0);
        check("t1_tokens", 32'(tokens), 0);
        check("t1_full",   32'(full),   0);
        check("t1_busy",   32'(busy),   0);
        check("t1_err",    32'(err),    0);
        rst = 1'b0;
        req = 2'b00;

        // T2: single requester.
        @(negedge clk);
        req = 2'b01;
        @(negedge clk);
        check("t2_sendout_rise", 32'(mer_sendout), 1);
        check("t2_busy",         32'(busy),        1);
        wait_gnt(g, gcyc);
        req = 2'b00;
        check("t2_gnt",     32'(g),       32'(2'b01));
        check("t2_tokens",  32'(tokens),  1);
        check("t2_sendout_low_at_gnt", 32'(mer_sendout), 0);
        @(negedge clk);
        check("t2_gnt_pulse", 32'(gnt), 0);
        wait_idle("t2_idle");

        // T3/T4: fairness, pacing, cap and refill from a clean reset.
        do_reset();
        last_gcyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                // Cap reached: requests must stall with no handshake.
                req    = 2'b11;
                seen_s = 1'b0;
                seen_g = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    if (mer_sendout) seen_s = 1'b1;
                    if (gnt != 2'b00) seen_g = 1'b1;
                end
                check("t4_cap_no_sendout", 32'(seen_s), 0);
                check("t4_cap_no_gnt",     32'(seen_g), 0);
                check("t4_cap_tokens",     32'(tokens), 4);
                check("t4_cap_full",       32'(full),   1);
            end
            wait_idle("vec_idle");
            req = vecs[i].req;
            for (int k = 0; k < vecs[i].n_ret; k++) begin
                ret_pulse = 1'b1;
                @(negedge clk);
                ret_pulse = 1'b0;
            end
            if (vecs[i].n_ret > 0) begin
                check("vec_tokens_after_ret", 32'(tokens), 32'(vecs[i].exp_tok) - 1);
                check("vec_full_after_ret",   32'(full),   0);
            end
            wait_gnt(g, gcyc);
            req = 2'b00;
            check("vec_gnt",    32'(g),      32'(vecs[i].exp_gnt));
            check("vec_tokens", 32'(tokens), 32'(vecs[i].exp_tok));
            check("vec_full",   32'(full),   32'(vecs[i].exp_full));
            if (i > 0) check("vec_spacing", 32'(gcyc - last_gcyc >= PACE_CYC), 1);
            last_gcyc = gcyc;
            @(negedge clk);
            check("vec_gnt_pulse", 32'(gnt), 0);
        end

        // T5a: retirement on the exact REQ->REL edge leaves tokens at 3.
        wait_idle("t5_idle");
        req = 2'b01;
        wait_sendout("t5_sendout");
        repeat (4) @(negedge clk);
        ret_pulse = 1'b1;
        @(negedge clk);
        ret_pulse = 1'b0;
        req       = 2'b00;
        check("t5_gnt_same_cycle",  32'(gnt),    32'(2'b01));
        check("t5_tokens_unchanged", 32'(tokens), 3);
        wait_idle("t5_idle2");

        // T5b: retirement with an empty ring is an error; err is sticky.
        do_reset();
        check("t5_reset_tokens", 32'(tokens), 0);
        ret_pulse = 1'b1;
        @(negedge clk);
        ret_pulse = 1'b0;
        check("t5_underflow_err",    32'(err),    1);
        check("t5_underflow_tokens", 32'(tokens), 0);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", 32'(err), 1);

        // Unsolicited ack while idle: DRAIN, err, no request.
        do_reset();
        check("drain_reset_err", 32'(err), 0);
        force_ack = 1'b1;
        repeat (4) @(negedge clk);
        check("drain_busy",    32'(busy),        1);
        check("drain_err",     32'(err),         1);
        check("drain_sendout", 32'(mer_sendout), 0);
        force_ack = 1'b0;
        wait_idle("drain_exit");

        // Reset in the middle of REQ drops mer_sendout at the next edge.
        do_reset();
        ack_en = 1'b0;
        req    = 2'b01;
        wait_sendout("rst_req_sendout");
        repeat (5) @(negedge clk);
        check("rst_req_holding", 32'(mer_sendout), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_sendout_low", 32'(mer_sendout), 0);
        check("rst_req_busy",        32'(busy),        0);
        check("rst_req_gnt",         32'(gnt),         0);
        check("rst_req_tokens",      32'(tokens),      0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // T6: merge stage never acks.
        @(negedge clk);
        req = 2'b01;
        wait_sendout("t6_sendout");
        hi     = 0;
        seen_g = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!mer_sendout) break;
            hi++;
            if (gnt != 2'b00) seen_g = 1'b1;
            @(negedge clk);
        end
        req = 2'b00;
        check("t6_no_gnt", 32'(seen_g), 0);
        check("t6_tokens", 32'(tokens), 0);
`ifdef HS_TIMEOUT_EN
        check("t6_sendout_cycles", 32'(hi),  TO_CYC);
        check("t6_timeout_err",    32'(err), 1);
        wait_idle("t6_idle");
`else
        check("t6_sendout_held", 32'(hi),  40);
        check("t6_no_err",       32'(err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
